// File: rtl/key_pkg.sv
// Shared constants and types for the key front end and the encoder stages.
package key_pkg;

    localparam int unsigned N_KEYS            = 8;
    localparam int unsigned IDX_W             = 3;
    localparam int unsigned DB_CYCLES_DEFAULT = 4;

    // Encoded key index, shared with the 8-to-3 encoder output.
    typedef logic [IDX_W-1:0] idx_t;

endpackage : key_pkg

// File: rtl/debounce_bit.sv
// Single-channel key conditioner: two-flop synchroniser followed by a
// stability counter that flips the debounced level only after DB_CYCLES
// consecutive synchronised samples disagree with it.
//   clk, rst_n : clock, async active-low reset
//   raw        : raw asynchronous key level
//   key        : debounced level (registered)
module debounce_bit
    import key_pkg::*;
#(
    parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic key
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES);

    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;

    // Synchroniser, counter and debounced level share one reset domain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            cnt <= '0;
            key <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (s2 == key) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
                key <= ~key;
                cnt <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule : debounce_bit

// File: rtl/key_request_conditioner.sv
// Key request conditioner: debounces N raw key lines, turns each debounced
// press into a sticky pending request for the downstream priority encoder,
// and retires requests one at a time via an index acknowledge.
//   clk, rst_n : clock, async active-low reset
//   raw_in     : raw key levels
//   ack/ack_idx: retire request ack_idx this cycle
//   ovr_clr    : clear sticky overrun flag
//   keys       : debounced key levels
//   press      : one-cycle rising-edge pulse per key (combinational)
//   req        : pending request vector
//   req_valid  : any request pending (combinational)
//   ovr        : sticky flag, press on an already-pending channel
module key_request_conditioner #(
    parameter int unsigned N         = key_pkg::N_KEYS,
    parameter int unsigned DB_CYCLES = key_pkg::DB_CYCLES_DEFAULT,
    parameter int unsigned IDX_W     = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     raw_in,
    input  logic             ack,
    input  logic [IDX_W-1:0] ack_idx,
    input  logic             ovr_clr,
    output logic [N-1:0]     keys,
    output logic [N-1:0]     press,
    output logic [N-1:0]     req,
    output logic             req_valid,
    output logic             ovr
);

    logic [N-1:0] keys_d;
    logic [N-1:0] clr_mask;

    // One debouncer per channel.
    for (genvar g = 0; g < N; g++) begin : g_ch
        debounce_bit #(
            .DB_CYCLES (DB_CYCLES)
        ) u_db (
            .clk   (clk),
            .rst_n (rst_n),
            .raw   (raw_in[g]),
            .key   (keys[g])
        );
    end

    assign press     = keys & ~keys_d;
    assign req_valid = |req;

    // One-hot retire mask; zero when no ack.
    always_comb begin
        clr_mask = '0;
        if (ack) begin
            clr_mask = N'(1) << ack_idx;
        end
    end

    // Pending requests and overrun: a new press always beats a clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            keys_d <= '0;
            req    <= '0;
            ovr    <= 1'b0;
        end else begin
            keys_d <= keys;
            req    <= (req & ~clr_mask) | press;
            if (|(press & req)) begin
                ovr <= 1'b1;
            end else if (ovr_clr) begin
                ovr <= 1'b0;
            end
        end
    end

endmodule : key_request_conditioner

// File: tb/tb_key_request_conditioner.sv
// Directed plus randomized checks of key_request_conditioner against a
// history-window reference model.
module tb_key_request_conditioner;
    import key_pkg::*;

    localparam int unsigned N  = N_KEYS;
    localparam int unsigned DB = DB_CYCLES_DEFAULT;

    logic         clk     = 1'b0;
    logic         rst_n   = 1'b1;
    logic [N-1:0] raw_in  = '0;
    logic         ack     = 1'b0;
    idx_t         ack_idx = '0;
    logic         ovr_clr = 1'b0;
    logic [N-1:0] keys;
    logic [N-1:0] press;
    logic [N-1:0] req;
    logic         req_valid;
    logic         ovr;

    int n_cmp  = 0;
    int n_fail = 0;

    key_request_conditioner #(
        .N         (N),
        .DB_CYCLES (DB),
        .IDX_W     (IDX_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_in    (raw_in),
        .ack       (ack),
        .ack_idx   (ack_idx),
        .ovr_clr   (ovr_clr),
        .keys      (keys),
        .press     (press),
        .req       (req),
        .req_valid (req_valid),
        .ovr       (ovr)
    );

    always #5 clk = ~clk;

    // Reference model: hist[k] is the raw value sampled k+1 edges ago.
    // The synchronised sample used at an edge is raw from two edges back;
    // a key flips when the last DB such samples all disagree with it.
    logic [N-1:0] hist [0:DB+1];
    logic [N-1:0] m_keys, m_keys_d, m_req;
    logic         m_ovr;

    function automatic logic [N-1:0] m_press();
        return m_keys & ~m_keys_d;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < DB + 2; k++) hist[k] = '0;
        m_keys   = '0;
        m_keys_d = '0;
        m_req    = '0;
        m_ovr    = 1'b0;
    endtask

    task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".keys"},  keys,      m_keys);
        check({tag, ".press"}, press,     m_press());
        check({tag, ".req"},   req,       m_req);
        check({tag, ".valid"}, N'(req_valid), N'(|m_req));
        check({tag, ".ovr"},   N'(ovr),   N'(m_ovr));
    endtask

    // Advance one clock edge, update the model, compare away from the edge.
    task automatic step();
        logic [N-1:0] p, clr, nk, raw_q;
        logic         nov;
        bit           all_diff;
        if (!rst_n) begin
            @(posedge clk); #1;
            model_reset();
        end else begin
            raw_q = raw_in;
            p     = m_press();
            clr   = ack ? (N'(1) << ack_idx) : '0;
            nk    = m_keys;
            for (int i = 0; i < N; i++) begin
                all_diff = 1'b1;
                for (int j = 0; j < DB; j++)
                    if (hist[1+j][i] == m_keys[i]) all_diff = 1'b0;
                if (all_diff) nk[i] = ~m_keys[i];
            end
            nov = (|(p & m_req)) ? 1'b1 : (ovr_clr ? 1'b0 : m_ovr);
            @(posedge clk); #1;
            m_req    = (m_req & ~clr) | p;
            m_ovr    = nov;
            m_keys_d = m_keys;
            m_keys   = nk;
            for (int k = DB + 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = raw_q;
        end
        check_all("step");
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Release then re-press key b; return with its press pulse pending.
    task automatic repress(input int b);
        bit seen;
        raw_in[b] = 1'b0;
        steps(DB + 4);
        raw_in[b] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 4 * DB + 8 && !seen; k++) begin
            if (m_press()[b]) seen = 1'b1;
            else step();
        end
        check("repress.seen", N'(seen), N'(1));
    endtask

    initial begin
        bit           glitch_seen;
        int           rise_edge;
        int           pulses;

        model_reset();

        // Asynchronous reset from power-up.
        #1 rst_n = 1'b0;
        #1 check_all("reset_init");
        rst_n  = 1'b1;

        // Fill state, then reset between edges.
        raw_in = 8'hFF;
        steps(DB + 4);
        check("fill.req", req, 8'hFF);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all("reset_async");
        check("reset_async.keys_zero", keys, 8'h00);
        step();
        raw_in = 8'h00;
        rst_n  = 1'b1;
        steps(DB + 4);

        // Clean press on key 0: keys at edge DB+2, req at DB+3.
        raw_in = 8'h01;
        steps(DB + 1);
        check("clean.keys_early", keys, 8'h00);
        step();
        check("clean.keys", keys, 8'h01);
        check("clean.press", press, 8'h01);
        step();
        check("clean.press_gone", press, 8'h00);
        check("clean.req", req, 8'h01);
        check("clean.valid", N'(req_valid), N'(1));

        // Glitch on key 3 shorter than the debounce window.
        glitch_seen = 1'b0;
        raw_in = 8'h09;
        for (int k = 0; k < 3; k++) begin
            step();
            if (keys[3] || press[3]) glitch_seen = 1'b1;
        end
        raw_in = 8'h01;
        for (int k = 0; k < DB + 6; k++) begin
            step();
            if (keys[3] || press[3]) glitch_seen = 1'b1;
        end
        check("glitch.none", N'(glitch_seen), N'(0));

        // Build req = 05, then retire by index.
        raw_in = 8'h05;
        steps(DB + 3);
        check("ack.setup", req, 8'h05);
        ack = 1'b1; ack_idx = 3'd2;
        step();
        check("ack.idx2", req, 8'h01);
        ack_idx = 3'd7;
        step();
        check("ack.idx7", req, 8'h01);
        ack_idx = 3'd0;
        step();
        check("ack.idx0", req, 8'h00);
        check("ack.valid", N'(req_valid), N'(0));
        ack = 1'b0;

        // Collision: press on key 2 while pending and being acked.
        repress(2);
        step();
        check("coll.pending", req, 8'h04);
        check("coll.no_ovr", N'(ovr), N'(0));
        repress(2);
        ack = 1'b1; ack_idx = 3'd2;
        step();
        ack = 1'b0;
        check("coll.req2", N'(req[2]), N'(1));
        check("coll.ovr", N'(ovr), N'(1));
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        check("coll.ovr_clr", N'(ovr), N'(0));

        // Reset in the middle of a debounce on key 7.
        raw_in = 8'h00;
        steps(DB + 4);
        raw_in = 8'h80;
        for (int k = 0; k < 4; k++) begin
            step();
            check("middb.no_press", press, 8'h00);
        end
        rst_n = 1'b0;
        #1 model_reset();
        step();
        rst_n = 1'b1;
        rise_edge = 0;
        pulses    = 0;
        for (int k = 1; k <= DB + 6; k++) begin
            step();
            if (keys[7] && rise_edge == 0) rise_edge = k;
            if (press[7]) pulses++;
        end
        check("middb.rise_edge", N'(rise_edge), N'(DB + 2));
        check("middb.pulses", N'(pulses), N'(1));

        // Randomized traffic against the model.
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 5) == 0)
                raw_in = raw_in ^ (8'($urandom) & 8'($urandom));
            ack     = ($urandom_range(0, 2) == 0);
            ack_idx = 3'($urandom);
            ovr_clr = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 199) == 0) begin
                rst_n = 1'b0;
                #1 model_reset();
                check_all("rand_reset");
                steps(2);
                rst_n = 1'b1;
            end
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_key_request_conditioner

// File: doc/key_request_conditioner.md
Name: key_request_conditioner

Overview:
- Upstream front end for the 8-to-3 priority encoder and the 74xx148-style encoder stages.
- Takes 8 raw, bouncing key/switch lines and synchronises and debounces each line.
- Converts each debounced press into a sticky pending request. The pending vector drives the encoder input `in[7:0]`.
- The downstream consumer retires one request at a time by returning the encoded index over an ack handshake.

Parameters:
- N, 8, number of key channels (encoder input width).
- DB_CYCLES, 4, consecutive stable synchronised samples required before the debounced level changes; legal range is 2 or more.
- IDX_W, $clog2(N) = 3, width of the ack index (matches encoder `out` width).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low; clears all state immediately.
- raw_in  input  N  raw asynchronous key levels, active-high.
- ack  input  1  consumer retires request `ack_idx` this cycle.
- ack_idx  input  IDX_W  index of the request being retired (encoder output code).
- ovr_clr  input  1  clears the sticky overrun flag.
- keys  output  N  debounced key levels.
- press  output  N  one-cycle rising-edge pulse per channel.
- req  output  N  pending request vector; feeds encoder `in`.
- req_valid  output  1  high when any bit of `req` is set (|req).
- ovr  output  1  sticky flag: a press arrived on a channel that was already pending.

Behaviour:
- **Reset.** Asynchronous, takes effect with no clock. The following all go to 0: synchroniser flops, counters, keys, the delayed copy of keys, req, and ovr. As a result press, req_valid and ovr all read 0.
- **Synchroniser.** Two-flop synchroniser per bit gives `s2`.
- **Debounce counter, per channel i:**
  - If `s2[i]` equals `keys[i]`: `cnt <= 0`.
  - Else if `cnt == DB_CYCLES-1`: `keys[i]` toggles and `cnt <= 0`.
  - Else: `cnt <= cnt + 1`.
  - Counter width is $clog2(DB_CYCLES).
- **Debounce latency.** A raw level set up before rising edge 1 and held updates `keys` at edge DB_CYCLES+2. With the default DB_CYCLES = 4, that is edge 6.
- **Glitch rejection.** A raw pulse shorter than DB_CYCLES synchronised cycles never changes `keys`.
- **press.** `press = keys & ~keys_d`, where `keys_d` is `keys` registered by one cycle. press is high for exactly one cycle after `keys` rises. A key release produces no pulse.
- **Pending register.** Updated on each edge as `req <= (req & ~clr_mask) | press`.
  - `clr_mask` is the one-hot decode of `ack_idx` when `ack` = 1, otherwise 0.
  - If set and clear hit the same bit on the same edge, set wins, so a new press is never lost.
- **Ack on a non-pending index.** No effect on req, and no error is raised.
- **Overrun.** `ovr` is set on any edge where `press & req` is non-zero, evaluated before the clear. It stays set until `ovr_clr` = 1. If set and `ovr_clr` occur on the same edge, set wins.
- **Multiple presses.** Simultaneous presses on several channels set all corresponding bits in one cycle. Arbitration is left to the downstream priority encoder.
- **End-to-end latency.** Raw input held through to `req` bit set takes DB_CYCLES+3 edges (edge 7 at the default DB_CYCLES).
- **Reset mid-operation.** Partial debounce counts are discarded. After rst_n is released, a still-pressed key must complete a full debounce before it produces a press.

Decomposition:
- Shared package `key_pkg` holds:
  - N_KEYS = 8
  - IDX_W = 3
  - DB_CYCLES_DEFAULT = 4
  - an `idx_t` typedef (logic [IDX_W-1:0]) that is also used by the encoder stages.
- Sub-module `debounce_bit`: a single channel containing synchroniser, counter and `keys` flop, parameterised by DB_CYCLES. It is instantiated N times in a generate loop.
- Edge detection, the pending register and the overrun flag stay in the top level.

Test Plan:
- **Reset.** Drive rst_n = 0 asynchronously between edges with `raw_in = 8'hFF` → keys, req, press, req_valid and ovr all drop to 0 immediately, before any clock edge.
- **Clean press.** `raw_in = 8'h01` held from before edge 1 →
  - `keys = 8'h01` after edge 6;
  - `press[0]` high only in the cycle between edges 6 and 7;
  - `req = 8'h01` and `req_valid = 1` after edge 7.
- **Glitch.** `raw_in[3]` high for 3 clocks then low → keys stays 8'h00 and press never asserts.
- **Ack.**
  - With `req = 8'h05`, ack = 1 and ack_idx = 2 → `req = 8'h01` after the next edge.
  - Then ack_idx = 7 → req stays 8'h01.
  - Then ack_idx = 0 → `req = 8'h00` and `req_valid = 0`.
- **Collision.**
  - Release and re-press key 2 so that `press[2]` coincides with ack = 1, ack_idx = 2 while `req[2] = 1` → req[2] stays 1 and ovr goes to 1.
  - Assert ovr_clr for one cycle → ovr returns to 0.
- **Reset mid-debounce.**
  - Hold `raw_in = 8'h80` and pulse rst_n low for one cycle after edge 4 → no press occurs before the reset.
  - After release, `keys[7]` rises at edge DB_CYCLES+2 counted from the first edge after rst_n deasserts, and press[7] pulses once.
